// File: rtl/regfile_view_sequencer.sv
// regfile_view_sequencer
//   Drives the 3-bit view select of the register-file checker output mux.
//   Views: 0 rd1, 1 rd2, 2 wd3, 3 a1, 4 a2, 5 a3. A debounced pushbutton
//   steps through the views; with auto_en set the views rotate on a timer,
//   and freeze pauses that rotation without losing the elapsed dwell.
//
// Parameters
//   DWELL_CYCLES : cycles each view is held in auto mode (>= 2)
//   DEB_CYCLES   : cycles the button must be stable to be accepted (>= 2)
//   NUM_VIEWS    : number of legal selm codes, 2..8
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn_n      in   raw pushbutton, active-low, asynchronous
//   auto_en    in   slide switch, 1 = auto-cycle
//   freeze     in   slide switch, 1 = pause auto-cycling
//   selm       out  view select (registered)
//   view_led   out  one-hot copy of selm (registered)
//   step_pulse out  one-cycle strobe aligned with each selm change
//   mode       out  00 MANUAL, 01 AUTO, 10 HOLD
//
// Build option
//   VIEW_SKIP_ADDR_EN : when defined, timed advances only rotate through the
//   data views 0..2; button presses still step through every view.

module regfile_view_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned DEB_CYCLES   = 1000000,
  parameter int unsigned NUM_VIEWS    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       auto_en,
  input  logic       freeze,
  output logic [2:0] selm,
  output logic [7:0] view_led,
  output logic       step_pulse,
  output logic [1:0] mode
);

  localparam int unsigned DW  = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned DBW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEB_CYCLES - 1);
  localparam logic [2:0]     LAST_VIEW  = 3'(NUM_VIEWS - 1);
`ifdef VIEW_SKIP_ADDR_EN
  localparam logic [2:0]     AUTO_LAST  = (NUM_VIEWS >= 3) ? 3'd2 : LAST_VIEW;
`endif

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    HOLD   = 2'b10
  } state_e;

  // Two-flop synchronisers; the button is held as an active-high "pressed"
  // level so that a cleared synchroniser reads as released.
  logic btn_meta_q, btn_sync_q;
  logic auto_meta_q, auto_sync_q;
  logic frz_meta_q, frz_sync_q;

  logic           btn_acc_q;
  logic [DBW-1:0] deb_cnt_q;
  logic           deb_diff, deb_done, press;

  state_e         state_q;
  logic [DW-1:0]  dwell_q;
  logic [2:0]     selm_q, selm_d, step_next;
  logic [7:0]     view_led_q;
  logic           step_q;
  logic           expire, advance;
`ifdef VIEW_SKIP_ADDR_EN
  logic [2:0]     auto_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      auto_meta_q <= 1'b0;
      auto_sync_q <= 1'b0;
      frz_meta_q  <= 1'b0;
      frz_sync_q  <= 1'b0;
    end else begin
      btn_meta_q  <= ~btn_n;
      btn_sync_q  <= btn_meta_q;
      auto_meta_q <= auto_en;
      auto_sync_q <= auto_meta_q;
      frz_meta_q  <= freeze;
      frz_sync_q  <= frz_meta_q;
    end
  end

  // Debounce: count consecutive cycles where the synchronised level disagrees
  // with the accepted one; accept on the DEB_CYCLES-th such cycle.
  always_comb begin
    deb_diff = (btn_sync_q != btn_acc_q);
    deb_done = deb_diff && (deb_cnt_q == DEB_LAST);
    press    = deb_done && btn_sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_acc_q <= 1'b0;
      deb_cnt_q <= '0;
    end else if (!deb_diff) begin
      deb_cnt_q <= '0;
    end else if (deb_done) begin
      btn_acc_q <= btn_sync_q;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  // A press and a dwell expiry in the same cycle collapse into one advance.
  always_comb begin
    expire    = (state_q == AUTO) && (dwell_q == DWELL_LAST);
    advance   = press || expire;
    step_next = (selm_q >= LAST_VIEW) ? '0 : selm_q + 3'd1;
`ifdef VIEW_SKIP_ADDR_EN
    auto_next = (selm_q >= AUTO_LAST) ? '0 : selm_q + 3'd1;
    if (press)       selm_d = step_next;
    else if (expire) selm_d = auto_next;
    else             selm_d = selm_q;
`else
    selm_d    = advance ? step_next : selm_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MANUAL;
      dwell_q    <= '0;
      selm_q     <= '0;
      view_led_q <= 8'h01;
      step_q     <= 1'b0;
    end else begin
      selm_q     <= selm_d;
      view_led_q <= 8'b1 << selm_d;
      step_q     <= advance;
      case (state_q)
        MANUAL: begin
          dwell_q <= '0;
          if (auto_sync_q) state_q <= AUTO;
        end
        AUTO: begin
          if (!auto_sync_q) begin
            state_q <= MANUAL;
            dwell_q <= '0;
          end else if (frz_sync_q) begin
            state_q <= HOLD;
            dwell_q <= advance ? '0 : dwell_q;
          end else begin
            dwell_q <= advance ? '0 : dwell_q + 1'b1;
          end
        end
        HOLD: begin
          // auto_en low wins over freeze release
          if (!auto_sync_q) begin
            state_q <= MANUAL;
            dwell_q <= '0;
          end else begin
            if (!frz_sync_q) state_q <= AUTO;
            dwell_q <= advance ? '0 : dwell_q;
          end
        end
        default: begin
          state_q <= MANUAL;
          dwell_q <= '0;
        end
      endcase
    end
  end

  assign selm       = selm_q;
  assign view_led   = view_led_q;
  assign step_pulse = step_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_regfile_view_sequencer.sv
module tb_regfile_view_sequencer;

  localparam int DWELL = 8;
  localparam int DEB   = 4;
  localparam int NV    = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       freeze = 1'b0;
  logic [2:0] selm;
  logic [7:0] view_led;
  logic       step_pulse;
  logic [1:0] mode;

  regfile_view_sequencer #(
    .DWELL_CYCLES(DWELL),
    .DEB_CYCLES  (DEB),
    .NUM_VIEWS   (NV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .auto_en   (auto_en),
    .freeze    (freeze),
    .selm      (selm),
    .view_led  (view_led),
    .step_pulse(step_pulse),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pipeline histories for the synchronisers, a run-length
  // count for the debounce, elapsed dwell time, and the view as an integer.
  bit m_b1, m_b2, m_a1, m_a2, m_f1, m_f2;
  bit m_acc;
  int m_run;
  int m_selm;
  int m_mode;   // 0 manual, 1 auto, 2 hold
  int m_dwell;
  bit m_step;

  typedef struct {
    logic       btn_n;
    logic       auto_en;
    logic       freeze;
    int         cycles;
    int         selm;
    logic [7:0] led;
    logic [1:0] mode;
    logic       step;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_b1 = 0; m_b2 = 0; m_a1 = 0; m_a2 = 0; m_f1 = 0; m_f2 = 0;
    m_acc = 0; m_run = 0; m_selm = 0; m_mode = 0; m_dwell = 0; m_step = 0;
  endfunction

  function automatic void model_step(input logic bn, input logic a, input logic f);
    bit press;
    bit expire;
    int nmode;
    press = 0;
    if (m_b2 != m_acc) begin
      m_run++;
      if (m_run == DEB) begin
        m_acc = m_b2;
        m_run = 0;
        press = m_acc;
      end
    end else begin
      m_run = 0;
    end
    expire = (m_mode == 1) && (m_dwell == DWELL - 1);
    nmode = m_mode;
    case (m_mode)
      0: begin
        m_dwell = 0;
        if (m_a2) nmode = 1;
      end
      1: begin
        if (!m_a2) begin nmode = 0; m_dwell = 0; end
        else if (m_f2) nmode = 2;
        else m_dwell++;
      end
      default: begin
        if (!m_a2) begin nmode = 0; m_dwell = 0; end
        else if (!m_f2) nmode = 1;
      end
    endcase
    if (press || expire) begin
      m_selm  = (m_selm + 1) % NV;
      m_dwell = 0;
    end
    m_step = press || expire;
    m_mode = nmode;
    m_b2 = m_b1; m_b1 = !bn;
    m_a2 = m_a1; m_a1 = a;
    m_f2 = m_f1; m_f1 = f;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(btn_n, auto_en, freeze);
    #1;
    check("model_selm", selm, m_selm);
    check("model_view_led", view_led, 1 << m_selm);
    check("model_step_pulse", step_pulse, m_step);
    check("model_mode", mode, m_mode);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_selm", selm, 0);
    check("rst_view_led", view_led, 8'h01);
    check("rst_mode", mode, 0);
    check("rst_step", step_pulse, 0);
    model_reset();
    tick();
    tick();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int first;
    int btn_left;

    // Manual wrap: low 6 cycles accepts a press, high 6 accepts the release.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6, 1, 8'h02, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 1, 8'h02, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6, 2, 8'h04, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 2, 8'h04, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6, 3, 8'h08, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 3, 8'h08, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6, 4, 8'h10, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 4, 8'h10, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6, 5, 8'h20, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 5, 8'h20, 2'b00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6, 0, 8'h01, 2'b00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 0, 8'h01, 2'b00, 1'b0});
    // Auto: 2 sync + 1 state-entry cycles, then one advance every 8.
    vecs.push_back('{1'b1, 1'b1, 1'b0, 11, 1, 8'h02, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8, 2, 8'h04, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8, 3, 8'h08, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8, 4, 8'h10, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8, 5, 8'h20, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8, 0, 8'h01, 2'b01, 1'b1});
    // Freeze: HOLD with dwell 5 retained, resume needs 3 more counts.
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 0, 8'h01, 2'b01, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 20, 0, 8'h01, 2'b10, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 5, 0, 8'h01, 2'b01, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1, 8'h02, 2'b01, 1'b1});

    model_reset();
    tick();
    tick();
    check("init_selm", selm, 0);
    check("init_view_led", view_led, 8'h01);
    check("init_mode", mode, 0);
    #2;
    rst = 1'b0;
    repeat (4) tick();

    // Short glitch must be rejected.
    pulses = 0;
    btn_n = 1'b0;
    repeat (3) begin tick(); pulses += int'(step_pulse); end
    btn_n = 1'b1;
    repeat (8) begin tick(); pulses += int'(step_pulse); end
    check("glitch_pulses", pulses, 0);
    check("glitch_selm", selm, 0);

    // Held press: exactly one advance, 2 + DEB cycles after the fall.
    btn_n = 1'b0;
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step_pulse) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("press_pulses", pulses, 1);
    check("press_latency", first, 2 + DEB);
    check("press_selm", selm, 1);
    btn_n = 1'b1;
    repeat (8) tick();

    repeat (2) begin
      btn_n = 1'b0;
      repeat (6) tick();
      btn_n = 1'b1;
      repeat (6) tick();
    end
    check("pre_reset_selm", selm, 3);
    async_reset();
    repeat (4) tick();

    foreach (vecs[i]) begin
      btn_n   = vecs[i].btn_n;
      auto_en = vecs[i].auto_en;
      freeze  = vecs[i].freeze;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_selm", i), selm, vecs[i].selm);
      check($sformatf("vec%0d_led", i), view_led, vecs[i].led);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      check($sformatf("vec%0d_step", i), step_pulse, vecs[i].step);
    end

    // Collision: press accepted on the same cycle the dwell expires at selm 2.
    repeat (10) tick();
    btn_n = 1'b0;
    pulses = 0;
    repeat (6) begin tick(); pulses += int'(step_pulse); end
    check("collision_selm", selm, 3);
    check("collision_pulses", pulses, 1);
    repeat (7) tick();
    check("collision_hold_selm", selm, 3);
    check("collision_hold_step", step_pulse, 0);
    tick();
    check("collision_next_selm", selm, 4);
    check("collision_next_step", step_pulse, 1);
    btn_n = 1'b1;
    auto_en = 1'b0;
    repeat (10) tick();

    // Randomised run against the model.
    btn_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (btn_left == 0) begin
        btn_n = ~btn_n;
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 29) == 0) freeze = ~freeze;
      if ($urandom_range(0, 699) == 0) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_view_sequencer.md
Name: regfile_view_sequencer

Overview:
- Sequences the 3-bit `selm` select of the register-file checker's output mux, choosing which of six 32-bit views drives HEX7..HEX0.
- View codes: 0 = rd1, 1 = rd2, 2 = wd3, 3 = a1, 4 = a2, 5 = a3.
- Supports manual stepping from a raw board pushbutton and timed auto-cycling, with a freeze control.
- Sits between the board KEY/SW inputs and the output mux; also drives LEDs that show which view is active.

Parameters:
- `DWELL_CYCLES`, default 50000000: clock cycles each view is held in auto mode (1 s at 50 MHz). Must be ≥ 2.
- `DEB_CYCLES`, default 1000000: cycles the synchronised button level must be stable before it is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `NUM_VIEWS`, default 6: number of valid `selm` codes, 0..NUM_VIEWS-1. Legal range 2..8.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `btn_n` input 1: raw pushbutton, active-low, asynchronous to `clk`.
- `auto_en` input 1: slide switch; 1 = auto-cycle, 0 = manual. Assumed static relative to `clk` (switch); synchronised internally regardless.
- `freeze` input 1: slide switch; 1 pauses auto-cycling. Synchronised internally.
- `selm` output 3: view select to the output mux.
- `view_led` output 8: one-hot copy of `selm` (bit n set when `selm` == n).
- `step_pulse` output 1: one-cycle strobe whenever `selm` changes.
- `mode` output 2: current state (00 MANUAL, 01 AUTO, 10 HOLD).

Behaviour:
- Reset (async assert, sync-to-clk deassert usage):
  - `selm` = 0, `view_led` = 8'h01, `step_pulse` = 0, `mode` = MANUAL.
  - Dwell counter, debounce counter, synchronisers and accepted button level cleared. The accepted level resets to released.
  - Reset mid-dwell or mid-debounce discards all progress.
- Input synchronisation: `btn_n`, `auto_en` and `freeze` each pass through a 2-flop synchroniser. All decisions below use the synchronised values.
- Debounce:
  - The counter increments while the synchronised button differs from the accepted level; it clears whenever they match.
  - When the counter reaches `DEB_CYCLES`-1, the accepted level updates and the counter clears.
  - `press` is a one-cycle pulse on the accepted released→pressed transition. Releases generate nothing.
  - Worst-case press latency from `btn_n` fall to `press`: 2 + `DEB_CYCLES` cycles.
- Advance operation:
  - `selm` ← (`selm` == NUM_VIEWS-1) ? 0 : `selm`+1.
  - The dwell counter clears.
  - `step_pulse` = 1 in the cycle after the advance decision, aligned with the new `selm`.
  - `view_led` is registered and updates in the same cycle as `selm`.
- State machine, evaluated each cycle; `press` is honoured in every state:
  - MANUAL: the dwell counter is held at 0. `press` → advance. Synchronised `auto_en` = 1 → AUTO, with the dwell counter starting from 0.
  - AUTO:
    - The dwell counter increments each cycle.
    - At `DWELL_CYCLES`-1 → advance.
    - `freeze` = 1 → HOLD, counter value retained.
    - `auto_en` = 0 → MANUAL, counter cleared.
  - HOLD:
    - The counter is frozen. `press` → advance (counter cleared).
    - `freeze` = 0 → AUTO, counting resumes from the retained value.
    - `auto_en` = 0 → MANUAL; `auto_en` takes priority over `freeze`.
- Simultaneous events:
  - `press` and dwell expiry in the same cycle → exactly one advance.
  - `press` together with a state change → the advance happens and the new state is entered with the counter at 0.
- `step_pulse` never asserts for two consecutive cycles except on back-to-back advances. These cannot occur while `DWELL_CYCLES` ≥ 2 and `DEB_CYCLES` ≥ 2.
- `selm` is never ≥ `NUM_VIEWS` after reset.

Optional Feature:
- Macro: `VIEW_SKIP_ADDR_EN`.
- Defined: in AUTO, the wrap point is 2. The sequence cycles 0→1→2→0, showing data views only. Manual `press` still steps through all `NUM_VIEWS` codes. If AUTO dwell expires while `selm` ≥ 3, the next value is 0.
- Undefined: AUTO and manual both cycle 0..NUM_VIEWS-1 identically.

Test Plan (`DWELL_CYCLES` = 8, `DEB_CYCLES` = 4, `NUM_VIEWS` = 6):
- Reset: assert `rst` mid-run with `selm` = 3 → `selm` = 0, `view_led` = 8'h01 and `mode` = 00 immediately, without waiting for a clock edge.
- Debounce: `btn_n` low for 3 cycles then high → no change. Then hold low for 10 cycles → `selm` 0→1 exactly once, `step_pulse` high for 1 cycle, pulse within 6 cycles of the fall.
- Manual wrap: 6 clean presses from 0 → `selm` = 1,2,3,4,5,0 and `view_led` = 02,04,08,10,20,01.
- Auto: `auto_en` = 1 → `selm` advances every 8 cycles through 0..5 then wraps to 0. With `VIEW_SKIP_ADDR_EN` defined, the sequence is 0,1,2,0.
- Freeze: `freeze` = 1 after 5 dwell cycles, hold for 20 cycles → `selm` unchanged, `mode` = 10. Release → advance 3 cycles later (counter resumed at 5).
- Collision: accepted press landing on the dwell-expiry cycle at `selm` = 2 → `selm` = 3, not 4. A single `step_pulse`. The next auto advance comes 8 cycles later.
